// File: rtl/sync_mem_pkg.sv
// Shared types and default parameters for the handshaked synchronous memory.
package sync_mem_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned RD_LAT_DEF = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO for read responses; output data reads as zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && valid;

    always_comb begin
        cnt_nxt = cnt + CNT_W'(push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt   <= cnt_nxt;
            valid <= (cnt_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_data;
        end
    end

    assign data = valid ? store[rd_ptr] : '0;

endmodule

// File: rtl/sync_mem_hs.sv
// Valid/ready single-port memory with self-clearing init and a bounded read response FIFO.
// Optional per-byte even parity is enabled by defining MEM_PARITY_EN.
module sync_mem_hs
    import sync_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_perr,
    output logic                init_done
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned EW    = DATA_W + 1;
    localparam int unsigned CNT_W = $clog2(RD_LAT + 2);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_addr_nxt;
    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]  out_cnt_nxt;
    logic              ready_nxt;

    logic              acc;
    logic              acc_rd;
    logic              acc_wr;
    logic              pop;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr;
    logic [EW-1:0]     rd_entry;
    logic              push_v;
    logic [EW-1:0]     push_d;
    logic [EW-1:0]     fifo_out;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign acc    = req_valid && req_ready && !reset;
    assign acc_rd = acc && !req_we;
    assign acc_wr = acc && req_we;
    assign pop    = rsp_valid && rsp_ready;

    // State, clear address, outstanding count and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            clr_addr  <= '0;
            out_cnt   <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_addr  <= clr_addr_nxt;
            out_cnt   <= out_cnt_nxt;
            req_ready <= ready_nxt;
            init_done <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        out_cnt_nxt  = out_cnt + CNT_W'(acc_rd) - CNT_W'(pop);
        ready_nxt    = 1'b0;
        case (state)
            INIT: begin
                clr_addr_nxt = clr_addr + ADDR_W'(1);
                if (clr_addr == '1) begin
                    state_nxt = RUN;
                end
            end
            default: ;
        endcase
        // Reads in flight plus queued responses must never exceed FIFO depth.
        ready_nxt = (state_nxt == RUN) && (out_cnt_nxt != CNT_W'(RD_LAT + 1));
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_addr] <= '0;
        end else if (acc_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[req_addr];

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par [2**ADDR_W];

    // Even parity per byte: stored bit equals XOR of the byte.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            par[clr_addr] <= '0;
        end else if (acc_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    par[req_addr][b] <= ^req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_perr = 1'b0;
        for (int b = 0; b < NB; b++) begin
            rd_perr = rd_perr | ((^rd_data[8*b +: 8]) ^ par[req_addr][b]);
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    assign rd_entry = {rd_perr, rd_data};

    // Array read at acceptance counts as the first latency stage.
    if (RD_LAT == 1) begin : g_direct
        assign push_v = acc_rd;
        assign push_d = rd_entry;
    end else begin : g_pipe
        logic [RD_LAT-2:0] pv;
        logic [EW-1:0]     pd [RD_LAT-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                pv <= '0;
            end else begin
                pv[0] <= acc_rd;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    pv[i] <= pv[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            pd[0] <= rd_entry;
            for (int i = 1; i < RD_LAT - 1; i++) begin
                pd[i] <= pd[i-1];
            end
        end

        assign push_v = pv[RD_LAT-2];
        assign push_d = pd[RD_LAT-2];
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (RD_LAT + 1)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_v),
        .push_data (push_d),
        .pop       (rsp_ready),
        .valid     (rsp_valid),
        .data      (fifo_out)
    );

    assign rsp_perr  = fifo_out[EW-1];
    assign rsp_rdata = fifo_out[DATA_W-1:0];

endmodule

// File: tb/tb_sync_mem_hs.sv
// Directed bench for sync_mem_hs (32-bit data, 256 words, read latency 3).
module tb_sync_mem_hs;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 8;
    localparam int unsigned LAT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_perr;
    logic          init_done;

    int n_assert = 0;
    int n_fail   = 0;

    sync_mem_hs #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .RD_LAT (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_perr  (rsp_perr),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Issue one read, wait (bounded) for its response, check latency/data/parity, then pop it.
    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp,
                          input logic exp_perr);
        int lat;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 16) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        chk({tag, "_data"}, rsp_rdata, exp);
        chk({tag, "_perr"}, 32'(rsp_perr), 32'(exp_perr));
        tick();
    endtask

    initial begin
        int acc;
        int got;
        int bad;
        logic stale;
        logic [31:0] exp_q [4];

        // Reset values
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_perr", 32'(rsp_perr), 32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);

        // Clear takes exactly 256 cycles after reset falls
        reset = 1'b0;
        for (int i = 0; i < 255; i++) tick();
        chk("init_done_255", 32'(init_done), 32'h0);
        chk("req_ready_255", 32'(req_ready), 32'h0);
        tick();
        chk("init_done_256", 32'(init_done), 32'h1);
        chk("req_ready_256", 32'(req_ready), 32'h1);

        rd_chk("rd_ff", 8'hFF, 32'h0, 1'b0);

        // Byte enables
        wr(8'd5, 32'hAABBCCDD, 4'b1111);
        wr(8'd5, 32'h11223344, 4'b0101);
        rd_chk("rd_be", 8'd5, 32'hAA22CC44, 1'b0);

        // Read right after write, and an all-zero byte-enable write
        wr(8'd9, 32'h12345678, 4'b1111);
        rd_chk("rd_raw", 8'd9, 32'h12345678, 1'b0);
        wr(8'd9, 32'hFFFFFFFF, 4'b0000);
        rd_chk("rd_be0", 8'd9, 32'h12345678, 1'b0);

        // Latency and ordering: back-to-back reads of 1,2,3
        wr(8'd1, 32'h00000101, 4'hF);
        wr(8'd2, 32'h00000202, 4'hF);
        wr(8'd3, 32'h00000303, 4'hF);
        req_valid = 1'b1;
        req_addr  = 8'd1;
        tick();
        chk("ord_v1", 32'(rsp_valid), 32'h0);
        req_addr = 8'd2;
        tick();
        chk("ord_v2", 32'(rsp_valid), 32'h0);
        req_addr = 8'd3;
        tick();
        req_valid = 1'b0;
        chk("ord_v3", 32'(rsp_valid), 32'h1);
        chk("ord_d3", rsp_rdata, 32'h101);
        tick();
        chk("ord_d4", rsp_rdata, 32'h202);
        tick();
        chk("ord_d5", rsp_rdata, 32'h303);
        tick();
        chk("ord_v6", 32'(rsp_valid), 32'h0);

        // Backpressure: only RD_LAT+1 reads may be outstanding
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_addr = 8'(acc + 1);
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'(LAT + 1));
        chk("bp_ready", 32'(req_ready), 32'h0);
        chk("bp_valid", 32'(rsp_valid), 32'h1);
        tick();
        tick();
        chk("bp_stable", rsp_rdata, 32'h101);
        exp_q[0] = 32'h101;
        exp_q[1] = 32'h202;
        exp_q[2] = 32'h303;
        exp_q[3] = 32'h0;
        rsp_ready = 1'b1;
        got = 0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) begin
                if (got < 4 && rsp_rdata !== exp_q[got]) bad++;
                got++;
            end
            tick();
        end
        chk("bp_drained", 32'(got), 32'h4);
        chk("bp_order", 32'(bad), 32'h0);
        chk("bp_ready_back", 32'(req_ready), 32'h1);

        // Throughput: one request per cycle with rsp_ready held high
        acc = 0;
        got = 0;
        bad = 0;
        req_addr = 8'd2;
        for (int i = 0; i < 20; i++) begin
            req_valid = (i < 8);
            if (req_valid && req_ready) acc++;
            if (rsp_valid) begin
                got++;
                if (rsp_rdata !== 32'h202) bad++;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("tp_accepted", 32'(acc), 32'h8);
        chk("tp_responses", 32'(got), 32'h8);
        chk("tp_data", 32'(bad), 32'h0);

        // Reset with two responses pending
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 8'd1;
        tick();
        req_addr = 8'd2;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        chk("mid_pending", 32'(rsp_valid), 32'h1);
        reset = 1'b1;
        tick();
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_init_done", 32'(init_done), 32'h0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tick();
            stale = stale | rsp_valid;
        end
        chk("mid_no_stale", 32'(stale), 32'h0);
        chk("mid_init_255", 32'(init_done), 32'h0);
        tick();
        chk("mid_init_256", 32'(init_done), 32'h1);
        rd_chk("rd_recleared", 8'd5, 32'h0, 1'b0);

        wr(8'd7, 32'h0F0F0F0F, 4'hF);
`ifdef MEM_PARITY_EN
        // Flip one stored data bit behind the parity bit's back
        dut.mem[7][0] = ~dut.mem[7][0];
        rd_chk("par_bad", 8'd7, 32'h0F0F0F0E, 1'b1);
        rd_chk("par_clean", 8'd2, 32'h0, 1'b0);
`else
        rd_chk("par_off", 8'd7, 32'h0F0F0F0F, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
